hs4_token_source: RTL and testbench

HS4_TOKEN_SOURCE -- requirements
Module: hs4_token_source

---
 rtl/hs4_token_source.sv | 171 +++++++++++++++++
 tb/tb_hs4_token_source.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hs4_token_source.sv
// hs4_token_source: clocked source of a four-phase req/ack bundled-data channel.
// Define HS4_SOURCE_TIMEOUT_EN to compile in the per-phase watchdog.
module hs4_token_source #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             req,
    output logic [WIDTH-1:0] data,
    input  logic             ack,
    output logic             busy,
    output logic [15:0]      tok_count,
    output logic             timeout,
    output logic             ack_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ_UP = 2'd1,
        ST_REQ_DN = 2'd2,
        ST_ERROR  = 2'd3
    } state_t;

    state_t                 state_r, state_nx_s;
    logic [SYNC_STAGES-1:0] ack_sync_r;
    logic [SYNC_STAGES-1:0] ack_fill_r;
    logic                   ack_s;
    logic                   sync_full_s;
    logic                   in_ready_s;
    logic                   accept_s;
    logic                   phase_expired_s;

    logic                   req_r, req_nx_s;
    logic [WIDTH-1:0]       data_r, data_nx_s;
    logic [15:0]            tok_count_r, tok_count_nx_s;
    logic                   timeout_r, timeout_nx_s;
    logic                   ack_err_r, ack_err_nx_s;

    // ack synchronizer; the fill chain keeps the port closed until the chain holds real samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_sync_r <= {SYNC_STAGES{1'b0}};
            ack_fill_r <= {SYNC_STAGES{1'b0}};
        end else begin
            ack_sync_r <= {ack_sync_r[SYNC_STAGES-2:0], ack};
            ack_fill_r <= {ack_fill_r[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign ack_s       = ack_sync_r[SYNC_STAGES-1];
    assign sync_full_s = ack_fill_r[SYNC_STAGES-1];
    assign in_ready_s  = (state_r == ST_IDLE) && sync_full_s && !ack_s;
    assign accept_s    = in_valid && in_ready_s;

`ifdef HS4_SOURCE_TIMEOUT_EN
    logic [15:0] phase_cnt_r, phase_cnt_nx_s;

    assign phase_expired_s = (phase_cnt_r == 16'(TIMEOUT - 1));

    // phase counter restarts on entry to each handshake phase
    always_comb begin
        phase_cnt_nx_s = 16'd0;
        if (((state_r == ST_REQ_UP) || (state_r == ST_REQ_DN)) && (state_nx_s == state_r)) begin
            phase_cnt_nx_s = phase_cnt_r + 16'd1;
        end else begin
            phase_cnt_nx_s = 16'd0;
        end
    end

    // phase counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_cnt_r <= 16'd0;
        end else begin
            phase_cnt_r <= phase_cnt_nx_s;
        end
    end
`else
    assign phase_expired_s = 1'b0;
`endif

    // handshake FSM next-state and registered-output values
    always_comb begin
        state_nx_s     = state_r;
        req_nx_s       = req_r;
        data_nx_s      = data_r;
        tok_count_nx_s = tok_count_r;
        timeout_nx_s   = timeout_r;
        ack_err_nx_s   = ack_err_r;
        case (state_r)
            ST_IDLE: begin
                if (ack_s) begin
                    ack_err_nx_s = 1'b1;
                end else begin
                    ack_err_nx_s = ack_err_r;
                end
                if (accept_s) begin
                    state_nx_s = ST_REQ_UP;
                    req_nx_s   = 1'b1;
                    data_nx_s  = in_data;
                end else begin
                    req_nx_s   = 1'b0;
                end
            end
            ST_REQ_UP: begin
                if (phase_expired_s) begin
                    state_nx_s   = ST_ERROR;
                    req_nx_s     = 1'b0;
                    timeout_nx_s = 1'b1;
                end else if (ack_s) begin
                    state_nx_s = ST_REQ_DN;
                    req_nx_s   = 1'b0;
                end else begin
                    req_nx_s   = 1'b1;
                end
            end
            ST_REQ_DN: begin
                if (phase_expired_s) begin
                    state_nx_s   = ST_ERROR;
                    req_nx_s     = 1'b0;
                    timeout_nx_s = 1'b1;
                end else if (!ack_s) begin
                    state_nx_s     = ST_IDLE;
                    tok_count_nx_s = tok_count_r + 16'd1;
                end else begin
                    req_nx_s = 1'b0;
                end
            end
            ST_ERROR: begin
                req_nx_s = 1'b0;
            end
            default: begin
                state_nx_s = ST_IDLE;
                req_nx_s   = 1'b0;
            end
        endcase
    end

    // FSM state and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            req_r       <= 1'b0;
            data_r      <= {WIDTH{1'b0}};
            tok_count_r <= 16'd0;
            timeout_r   <= 1'b0;
            ack_err_r   <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            req_r       <= req_nx_s;
            data_r      <= data_nx_s;
            tok_count_r <= tok_count_nx_s;
            timeout_r   <= timeout_nx_s;
            ack_err_r   <= ack_err_nx_s;
        end
    end

    assign in_ready  = in_ready_s;
    assign req       = req_r;
    assign data      = data_r;
    assign busy      = (state_r != ST_IDLE);
    assign tok_count = tok_count_r;
    assign timeout   = timeout_r;
    assign ack_err   = ack_err_r;

endmodule

// File: tb/tb_hs4_token_source.sv
// tb_hs4_token_source: randomized self-checking bench for hs4_token_source, with an ack
// loopback of configurable delay and a protocol-timing reference model.
module tb_hs4_token_source;
    localparam int W  = 8;
    localparam int S  = 2;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          req;
    logic [W-1:0]  data;
    logic          ack;
    logic          busy;
    logic [15:0]   tok_count;
    logic          timeout;
    logic          ack_err;

    int            tests_run = 0;
    int            tests_failed = 0;
    int            cyc = 0;
    logic [7:0]    req_hist = 8'h00;
    int            ack_delay = 0;
    logic          ack_man_en = 1'b0;
    logic          ack_man = 1'b0;
    logic [15:0]   exp_cnt = 16'd0;

    hs4_token_source #(.WIDTH(W), .SYNC_STAGES(S), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .req(req), .data(data), .ack(ack), .busy(busy),
        .tok_count(tok_count), .timeout(timeout), .ack_err(ack_err)
    );

    always #5 clk = ~clk;

    // environment: cycle counter and req history for the delayed loopback
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        req_hist <= {req_hist[6:0], req};
    end

    // ack is either driven by hand or is req delayed by ack_delay clock cycles
    always_comb begin
        if (ack_man_en) ack = ack_man;
        else if (ack_delay == 0) ack = req;
        else ack = req_hist[ack_delay-1];
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1; exp_cnt = 16'd0;
        repeat (S + 2) @(negedge clk);
    endtask

    // offer d starting at a negedge; returns #1 after the accepting edge
    task automatic send(input logic [W-1:0] d, output bit ok);
        ok = 1'b0; in_valid = 1'b1; in_data = d;
        for (int i = 0; i < 400; i++) begin
            if (in_ready === 1'b1) begin
                @(posedge clk); ok = 1'b1; break;
            end
            @(negedge clk);
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 500) begin
            @(posedge clk); #1; n++;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests_run++;
        if ({req, busy, timeout, ack_err} !== 4'b0000) begin
            tests_failed++; $display("FAIL reset_flags: req/busy/timeout/ack_err=%b want 0000", {req, busy, timeout, ack_err});
        end
        tests_run++;
        if (data !== 8'h00 || tok_count !== 16'h0000) begin
            tests_failed++; $display("FAIL reset_regs: data=%h tok_count=%h want 00/0000", data, tok_count);
        end
        rst_n = 1'b1;
        repeat (S + 2) @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL reset_ready: in_ready=%b want 1", in_ready);
        end
    endtask

    task automatic test_single();
        bit ok; int n;
        ack_man_en = 1'b0; ack_delay = 3;
        send(8'hA5, ok);
        tests_run++;
        if (!ok || req !== 1'b1 || data !== 8'hA5) begin
            tests_failed++; $display("FAIL single_accept: ok=%0b req=%b data=%h want 1/1/a5", ok, req, data);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ack === 1'b1) break;
        end
        @(posedge clk);
        n = 0;
        while (req === 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        tests_run++;
        if (n != S || data !== 8'hA5) begin
            tests_failed++; $display("FAIL single_req_fall: cycles=%0d data=%h want %0d/a5", n, data, S);
        end
        wait_idle(n);
        exp_cnt++;
        tests_run++;
        if (busy !== 1'b0 || tok_count !== exp_cnt) begin
            tests_failed++; $display("FAIL single_count: busy=%b tok_count=%h want 0/%h", busy, tok_count, exp_cnt);
        end
        @(negedge clk);
        ack_delay = 0;
    endtask

    task automatic test_back_to_back();
        int acc_cyc[8]; logic [W-1:0] got[8]; int idx; int n;
        repeat (8) @(negedge clk);
        ack_man_en = 1'b0; ack_delay = 0;
        idx = 0; in_valid = 1'b1; in_data = 8'h01;
        for (int i = 0; i < 300 && idx < 8; i++) begin
            if (in_ready === 1'b1) begin
                @(posedge clk); #1;
                acc_cyc[idx] = cyc; got[idx] = data; idx++;
                in_data = 8'(idx + 1);
                if (idx == 8) in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        tests_run++;
        if (idx != 8) begin
            tests_failed++; $display("FAIL b2b_accepts: got %0d want 8", idx);
        end
        for (int k = 0; k < idx; k++) begin
            tests_run++;
            if (got[k] !== 8'(k + 1)) begin
                tests_failed++; $display("FAIL b2b_data[%0d]: got %h want %h", k, got[k], 8'(k + 1));
            end
            if (k > 0) begin
                tests_run++;
                if (acc_cyc[k] - acc_cyc[k-1] != 2 * S + 3) begin
                    tests_failed++; $display("FAIL b2b_period[%0d]: got %0d want %0d", k, acc_cyc[k] - acc_cyc[k-1], 2 * S + 3);
                end
            end
        end
        wait_idle(n);
        exp_cnt = exp_cnt + 16'd8;
        tests_run++;
        if (tok_count !== exp_cnt) begin
            tests_failed++; $display("FAIL b2b_count: got %h want %h", tok_count, exp_cnt);
        end
    endtask

    task automatic test_ack_err();
        bit ok; int n;
        @(negedge clk);
        tests_run++;
        if (ack_err !== 1'b0) begin
            tests_failed++; $display("FAIL ackerr_pre: got %b want 0", ack_err);
        end
        ack_man_en = 1'b1; ack_man = 1'b1;
        repeat (S + 1) @(negedge clk);
        tests_run++;
        if (ack_err !== 1'b1 || in_ready !== 1'b0) begin
            tests_failed++; $display("FAIL ackerr_set: ack_err=%b in_ready=%b want 1/0", ack_err, in_ready);
        end
        in_valid = 1'b1; in_data = 8'h3C; ack_man = 1'b0;
        repeat (S - 1) begin
            @(negedge clk);
            tests_run++;
            if (in_ready !== 1'b0 || busy !== 1'b0) begin
                tests_failed++; $display("FAIL ackerr_hold: in_ready=%b busy=%b want 0/0", in_ready, busy);
            end
        end
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL ackerr_release: in_ready=%b want 1", in_ready);
        end
        ack_man_en = 1'b0; ack_delay = 0;
        send(8'h3C, ok);
        wait_idle(n);
        exp_cnt++;
        tests_run++;
        if (!ok || data !== 8'h3C || tok_count !== exp_cnt || ack_err !== 1'b1) begin
            tests_failed++; $display("FAIL ackerr_token: ok=%0b data=%h tok_count=%h ack_err=%b want 1/3c/%h/1", ok, data, tok_count, ack_err, exp_cnt);
        end
        do_reset();
    endtask

    task automatic test_timeout();
        bit ok; int n;
        ack_man_en = 1'b1; ack_man = 1'b0;
        send(8'h5A, ok);
`ifdef HS4_SOURCE_TIMEOUT_EN
        n = 0;
        while (req === 1'b1 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        tests_run++;
        if (!ok || n != TO || timeout !== 1'b1) begin
            tests_failed++; $display("FAIL timeout_fire: ok=%0b cycles=%0d timeout=%b want 1/%0d/1", ok, n, timeout, TO);
        end
        repeat (4) begin
            @(negedge clk);
            tests_run++;
            if ({req, in_ready, busy, timeout} !== 4'b0011) begin
                tests_failed++; $display("FAIL timeout_error_state: req/in_ready/busy/timeout=%b want 0011", {req, in_ready, busy, timeout});
            end
        end
        ack_man_en = 1'b0;
`else
        repeat (100) @(negedge clk);
        tests_run++;
        if (!ok || {req, busy, timeout} !== 3'b110) begin
            tests_failed++; $display("FAIL no_timeout_wait: ok=%0b req/busy/timeout=%b want 1/110", ok, {req, busy, timeout});
        end
        ack_man_en = 1'b0; ack_delay = 0;
        wait_idle(n);
        exp_cnt++;
        tests_run++;
        if (tok_count !== exp_cnt || timeout !== 1'b0) begin
            tests_failed++; $display("FAIL no_timeout_finish: tok_count=%h timeout=%b want %h/0", tok_count, timeout, exp_cnt);
        end
`endif
        do_reset();
        tests_run++;
        if (timeout !== 1'b0 || busy !== 1'b0) begin
            tests_failed++; $display("FAIL timeout_cleared: timeout=%b busy=%b want 0/0", timeout, busy);
        end
    endtask

    task automatic test_reset_mid();
        bit ok; int n;
        ack_man_en = 1'b0; ack_delay = 0;
        send(8'h11, ok);
        wait_idle(n);
        @(negedge clk);
        ack_man_en = 1'b1; ack_man = 1'b0;
        send(8'h77, ok);
        ack_man = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req === 1'b0) break;
        end
        tests_run++;
        if (req !== 1'b0 || busy !== 1'b1 || tok_count !== 16'd1) begin
            tests_failed++; $display("FAIL rstmid_in_dn: req=%b busy=%b tok_count=%h want 0/1/0001", req, busy, tok_count);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (req !== 1'b0 || tok_count !== 16'd0 || busy !== 1'b0 || data !== 8'h00) begin
            tests_failed++; $display("FAIL rstmid_async: req=%b tok_count=%h busy=%b data=%h want 0/0000/0/00", req, tok_count, busy, data);
        end
        @(negedge clk);
        rst_n = 1'b1; exp_cnt = 16'd0;
        in_valid = 1'b1; in_data = 8'h99;
        repeat (6) begin
            @(negedge clk);
            tests_run++;
            if (req !== 1'b0 || in_ready !== 1'b0) begin
                tests_failed++; $display("FAIL rstmid_no_accept: req=%b in_ready=%b want 0/0", req, in_ready);
            end
        end
        ack_man = 1'b0;
        send(8'h99, ok);
        tests_run++;
        if (!ok || req !== 1'b1 || data !== 8'h99) begin
            tests_failed++; $display("FAIL rstmid_accept: ok=%0b req=%b data=%h want 1/1/99", ok, req, data);
        end
        ack_man_en = 1'b0;
        wait_idle(n);
        exp_cnt++;
        tests_run++;
        if (tok_count !== exp_cnt) begin
            tests_failed++; $display("FAIL rstmid_count: got %h want %h", tok_count, exp_cnt);
        end
        do_reset();
    endtask

    task automatic test_wrap();
        bit ok; int n;
        ack_man_en = 1'b0; ack_delay = 0;
        dut.tok_count_r = 16'hFFFE;
        exp_cnt = 16'hFFFE;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            send(8'(8'hE0 + k), ok);
            wait_idle(n);
            exp_cnt = exp_cnt + 16'd1;
            tests_run++;
            if (!ok || tok_count !== exp_cnt) begin
                tests_failed++; $display("FAIL wrap_count[%0d]: ok=%0b got %h want %h", k, ok, tok_count, exp_cnt);
            end
        end
        tests_run++;
        if (tok_count !== 16'h0000 || ack_err !== 1'b0 || timeout !== 1'b0) begin
            tests_failed++; $display("FAIL wrap_flags: tok_count=%h ack_err=%b timeout=%b want 0000/0/0", tok_count, ack_err, timeout);
        end
    endtask

    task automatic test_random();
        bit ok; int n; int d; logic [W-1:0] v;
        ack_man_en = 1'b0;
        for (int t = 0; t < 24; t++) begin
            repeat (8) @(negedge clk);
            d = $urandom_range(0, 3);
            ack_delay = d;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            v = W'($urandom);
            send(v, ok);
            tests_run++;
            if (!ok || req !== 1'b1 || data !== v) begin
                tests_failed++; $display("FAIL rand_accept[%0d]: ok=%0b req=%b data=%h want 1/1/%h", t, ok, req, data, v);
            end
            wait_idle(n);
            exp_cnt++;
            tests_run++;
            if (n != 2 * (d + S) + 2 || tok_count !== exp_cnt || data !== v) begin
                tests_failed++; $display("FAIL rand_handshake[%0d]: cycles=%0d tok_count=%h data=%h want %0d/%h/%h", t, n, tok_count, data, 2 * (d + S) + 2, exp_cnt, v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_ack_err();
        test_timeout();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
